// File: rtl/hamming_secded_checker.sv
// Hamming(7,4)+overall-parity SECDED checker for a protected 8-bit register.
// Two-stage pipeline (syndrome, then correction) under a single global stall,
// plus saturating corrected/uncorrectable counters and a sticky error alarm.
module hamming_secded_checker #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_cw,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_data,
    output logic [7:0]         out_cw,
    output logic [2:0]         out_syndrome,
    output logic               out_corrected,
    output logic               out_uncorr,
    input  logic               clr_counts,
    output logic [COUNT_W-1:0] corr_count,
    output logic [COUNT_W-1:0] uncorr_count,
    output logic               err_alarm
);

    localparam int STAGES = 2;

    typedef struct packed {
        logic [3:0] data;
        logic [7:0] cw;
        logic [2:0] syn;
        logic       corrected;
        logic       uncorr;
    } result_t;

    // Valid bit per pipeline stage; [STAGES] is the output stage.
    logic [STAGES:1] vld_pipe_q, vld_pipe_d;

    logic [7:0] s1_cw_q, s1_cw_d;
    logic [2:0] s1_syn_q, s1_syn_d;
    logic       s1_par_q, s1_par_d;

    result_t    res_q, res_d;

    logic [COUNT_W-1:0] corr_count_q, corr_count_d;
    logic [COUNT_W-1:0] uncorr_count_q, uncorr_count_d;
    logic               err_alarm_q, err_alarm_d;

    logic stall;
    logic xfer;

    // Any unaccepted result freezes the whole pipe, so nothing is dropped.
    assign stall = vld_pipe_q[STAGES] & ~out_ready;
    assign xfer  = vld_pipe_q[STAGES] & out_ready;

    // Stage 1: capture the raw word with its syndrome and overall parity.
    always_comb begin
        vld_pipe_d = vld_pipe_q;
        s1_cw_d    = s1_cw_q;
        s1_syn_d   = s1_syn_q;
        s1_par_d   = s1_par_q;
        if (!stall) begin
            vld_pipe_d  = {vld_pipe_q[STAGES-1:1], in_valid};
            s1_cw_d     = in_cw;
            s1_syn_d[0] = in_cw[0] ^ in_cw[2] ^ in_cw[4] ^ in_cw[6];
            s1_syn_d[1] = in_cw[1] ^ in_cw[2] ^ in_cw[5] ^ in_cw[6];
            s1_syn_d[2] = in_cw[3] ^ in_cw[4] ^ in_cw[5] ^ in_cw[6];
            s1_par_d    = ^in_cw;
        end
    end

    // Stage 2: classify and correct; a double error passes the raw word through.
    always_comb begin
        logic [7:0] fix;
        fix   = s1_cw_q;
        res_d = res_q;
        if (s1_par_q) begin
            // Odd overall parity means one flipped bit; syndrome 0 points at cw[7].
            if (s1_syn_q != 3'd0) fix[s1_syn_q - 3'd1] = ~fix[s1_syn_q - 3'd1];
            else                  fix[7]               = ~fix[7];
        end
        if (!stall) begin
            res_d.cw        = fix;
            res_d.data      = {fix[6], fix[5], fix[4], fix[2]};
            res_d.syn       = s1_syn_q;
            res_d.corrected = s1_par_q;
            res_d.uncorr    = ~s1_par_q & (s1_syn_q != 3'd0);
        end
    end

    // Statistics: count transferred results, saturate, clear has priority.
    always_comb begin
        corr_count_d   = corr_count_q;
        uncorr_count_d = uncorr_count_q;
        err_alarm_d    = err_alarm_q;
        if (clr_counts) begin
            corr_count_d   = '0;
            uncorr_count_d = '0;
            err_alarm_d    = 1'b0;
        end else if (xfer) begin
            if (res_q.corrected && corr_count_q != {COUNT_W{1'b1}})
                corr_count_d = corr_count_q + COUNT_W'(1);
            if (res_q.uncorr) begin
                err_alarm_d = 1'b1;
                if (uncorr_count_q != {COUNT_W{1'b1}})
                    uncorr_count_d = uncorr_count_q + COUNT_W'(1);
            end
        end
    end

    // State registers; reset empties the pipe and clears all statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q     <= '0;
            s1_cw_q        <= '0;
            s1_syn_q       <= '0;
            s1_par_q       <= 1'b0;
            res_q          <= '0;
            corr_count_q   <= '0;
            uncorr_count_q <= '0;
            err_alarm_q    <= 1'b0;
        end else begin
            vld_pipe_q     <= vld_pipe_d;
            s1_cw_q        <= s1_cw_d;
            s1_syn_q       <= s1_syn_d;
            s1_par_q       <= s1_par_d;
            res_q          <= res_d;
            corr_count_q   <= corr_count_d;
            uncorr_count_q <= uncorr_count_d;
            err_alarm_q    <= err_alarm_d;
        end
    end

    assign in_ready      = ~stall;
    assign out_valid     = vld_pipe_q[STAGES];
    assign out_data      = res_q.data;
    assign out_cw        = res_q.cw;
    assign out_syndrome  = res_q.syn;
    assign out_corrected = res_q.corrected;
    assign out_uncorr    = res_q.uncorr;
    assign corr_count    = corr_count_q;
    assign uncorr_count  = uncorr_count_q;
    assign err_alarm     = err_alarm_q;

endmodule

// File: tb/tb_hamming_secded_checker.sv
// Scoreboard bench for hamming_secded_checker with 2-bit counters.
module tb_hamming_secded_checker;

    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [7:0]    in_cw;
    logic          out_valid, out_ready;
    logic [3:0]    out_data;
    logic [7:0]    out_cw;
    logic [2:0]    out_syndrome;
    logic          out_corrected, out_uncorr;
    logic          clr_counts;
    logic [CW-1:0] corr_count, uncorr_count;
    logic          err_alarm;

    hamming_secded_checker #(.COUNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_cw(out_cw), .out_syndrome(out_syndrome),
        .out_corrected(out_corrected), .out_uncorr(out_uncorr),
        .clr_counts(clr_counts), .corr_count(corr_count),
        .uncorr_count(uncorr_count), .err_alarm(err_alarm)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] d;
        logic [7:0] cw;
        logic [2:0] syn;
        logic       c;
        logic       u;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Present a word until accepted; expected result is queued at acceptance.
    task automatic send(input logic [7:0] cw, input logic [3:0] d, input logic [7:0] ecw,
                        input logic [2:0] syn, input logic c, input logic u);
        bit acc = 0;
        exp_t e;
        in_valid = 1'b1;
        in_cw    = cw;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.d = d; e.cw = ecw; e.syn = syn; e.c = c; e.u = u;
                q.push_back(e);
                acc = 1;
            end
            @(posedge clk); #1;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
        chk("drain", q.size(), 0);
        @(posedge clk); #1;
    endtask

    // Monitor: pops on every result transfer, tracks counters and stall stability.
    int   exp_corr = 0, exp_unc = 0;
    bit   exp_alarm = 0;
    bit   prev_stall = 0;
    exp_t snap;

    always @(negedge clk) begin
        exp_t e;
        bit   popped;
        popped = 0;
        if (rst) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_cw", out_cw, 0);
            chk("rst_flags", {out_syndrome, out_corrected, out_uncorr}, 0);
            chk("rst_counts", {corr_count, uncorr_count, err_alarm}, 0);
            exp_corr = 0; exp_unc = 0; exp_alarm = 0; prev_stall = 0;
        end else begin
            chk("corr_count", corr_count, exp_corr);
            chk("uncorr_count", uncorr_count, exp_unc);
            chk("err_alarm", err_alarm, exp_alarm);
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    popped = 1;
                    chk("out_data", out_data, e.d);
                    chk("out_cw", out_cw, e.cw);
                    chk("out_syndrome", out_syndrome, e.syn);
                    chk("out_corrected", out_corrected, e.c);
                    chk("out_uncorr", out_uncorr, e.u);
                end
            end
            if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
            if (prev_stall) begin
                chk("stall_valid_held", out_valid, 1);
                chk("stall_out_held", {out_data, out_cw, out_syndrome, out_corrected, out_uncorr}, snap);
            end
            prev_stall = out_valid && !out_ready;
            snap = {out_data, out_cw, out_syndrome, out_corrected, out_uncorr};
            if (clr_counts) begin
                exp_corr = 0; exp_unc = 0; exp_alarm = 0;
            end else if (popped) begin
                if (e.c && exp_corr != CMAX) exp_corr++;
                if (e.u) begin
                    exp_alarm = 1;
                    if (exp_unc != CMAX) exp_unc++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_cw = 8'h00; out_ready = 1'b1; clr_counts = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        // Clean word and 2-cycle latency.
        send(8'h55, 4'b1011, 8'h55, 3'b000, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk); chk("lat_early", out_valid, 0);
        @(negedge clk); chk("lat_2cyc", out_valid, 1);
        drain();

        // Single data error, parity-bit error, double error, syndrome-7 error.
        send(8'h51, 4'b1011, 8'h55, 3'b011, 1'b1, 1'b0); drain();
        chk("corr_after_d0", corr_count, 1);
        send(8'hD5, 4'b1011, 8'h55, 3'b000, 1'b1, 1'b0); drain();
        chk("corr_after_p8", corr_count, 2);
        send(8'h41, 4'b1000, 8'h41, 3'b110, 1'b0, 1'b1); drain();
        chk("uncorr_after_dbl", uncorr_count, 1);
        chk("alarm_after_dbl", err_alarm, 1);
        send(8'hBF, 4'b1111, 8'hFF, 3'b111, 1'b1, 1'b0); drain();
        chk("corr_after_d3", corr_count, 3);

        // Backpressure: 4-word stream with out_ready low for 3 cycles.
        send(8'h55, 4'b1011, 8'h55, 3'b000, 1'b0, 1'b0);
        send(8'h7F, 4'b1111, 8'hFF, 3'b000, 1'b1, 1'b0);
        out_ready = 1'b0;
        fork
            begin repeat (3) @(posedge clk); #1 out_ready = 1'b1; end
        join_none
        in_valid = 1'b1; in_cw = 8'h41;
        @(negedge clk); chk("bp_in_ready_low", in_ready, 0);
        @(posedge clk); #1;
        send(8'h41, 4'b1000, 8'h41, 3'b110, 1'b0, 1'b1);
        send(8'h00, 4'b0000, 8'h00, 3'b000, 1'b0, 1'b0);
        drain();
        chk("bp_corr_sat", corr_count, 3);
        chk("bp_uncorr", uncorr_count, 2);

        // Idle clear, then saturation with 5 single errors.
        clr_counts = 1'b1; @(posedge clk); #1 clr_counts = 1'b0;
        chk("clr_corr", corr_count, 0);
        chk("clr_alarm", err_alarm, 0);
        for (int i = 0; i < 5; i++) send(8'h51, 4'b1011, 8'h55, 3'b011, 1'b1, 1'b0);
        drain();
        chk("sat_corr", corr_count, 3);
        chk("sat_uncorr", uncorr_count, 0);

        // Clear coinciding with a corrected transfer, then with an uncorrectable one.
        send(8'h51, 4'b1011, 8'h55, 3'b011, 1'b1, 1'b0);
        in_valid = 1'b0;
        @(posedge clk); #1 clr_counts = 1'b1;
        @(posedge clk); #1 clr_counts = 1'b0;
        chk("clr_vs_corr", corr_count, 0);
        send(8'h41, 4'b1000, 8'h41, 3'b110, 1'b0, 1'b1);
        in_valid = 1'b0;
        @(posedge clk); #1 clr_counts = 1'b1;
        @(posedge clk); #1 clr_counts = 1'b0;
        chk("clr_vs_uncorr", uncorr_count, 0);
        chk("clr_vs_alarm", err_alarm, 0);
        drain();

        // Mid-stream reset discards in-flight words.
        send(8'h55, 4'b1011, 8'h55, 3'b000, 1'b0, 1'b0);
        send(8'h51, 4'b1011, 8'h55, 3'b011, 1'b1, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        q.delete();
        @(posedge clk); @(posedge clk); #3 rst = 1'b0;
        send(8'h7F, 4'b1111, 8'hFF, 3'b000, 1'b1, 1'b0);
        in_valid = 1'b0;
        @(negedge clk); chk("rst_lat_early", out_valid, 0);
        @(negedge clk); chk("rst_lat_2cyc", out_valid, 1);
        drain();
        chk("rst_then_corr", corr_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
